// File: rtl/board_writer.sv
// Tic-tac-toe board-state writer: accepts one move per handshake,
// validates it against the board, writes legal moves and alternates turns.
module board_writer (
    input  logic       clock,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    input  logic       game_over,
    output logic       move_ready,
    output logic       move_accepted,
    output logic       illegal_move,
    output logic       turn,
    output logic [3:0] move_count,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9
);

    typedef enum logic [1:0] {
        PLAY_X = 2'd0,
        PLAY_O = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_board [9];
    logic [3:0] r_count;
    logic       r_turn;
    logic       r_acc;
    logic       r_ill;

    logic       w_in_range;
    logic [1:0] w_cell;
    logic       w_legal;
    logic       w_write;
    logic       w_reject;
    logic [1:0] w_mark;

    // Look up the addressed cell; out-of-range positions read as occupied-free
    // but are rejected by the range check anyway.
    always_comb begin
        w_in_range = (move_pos >= 4'd1) && (move_pos <= 4'd9);
        w_cell     = 2'b00;
        for (int i = 0; i < 9; i++) begin
            if (move_pos == 4'(i + 1)) begin
                w_cell = r_board[i];
            end
        end
        w_legal = w_in_range && (w_cell == 2'b00);
        w_mark  = (r_state == PLAY_O) ? 2'b10 : 2'b01;
    end

    // Next-state and handshake decode: new_game beats game_over beats a move.
    always_comb begin
        w_next     = r_state;
        w_write    = 1'b0;
        w_reject   = 1'b0;
        move_ready = 1'b0;
        unique case (r_state)
            PLAY_X, PLAY_O: begin
                move_ready = 1'b1;
                if (new_game) begin
                    w_next = PLAY_X;
                end else if (game_over) begin
                    w_next = DONE;
                end else if (move_valid) begin
                    if (w_legal) begin
                        w_write = 1'b1;
                        if (r_count == 4'd8) begin
                            w_next = DONE;
                        end else if (r_state == PLAY_X) begin
                            w_next = PLAY_O;
                        end else begin
                            w_next = PLAY_X;
                        end
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            DONE: begin
                if (new_game) begin
                    w_next = PLAY_X;
                end
            end
            default: begin
                w_next = PLAY_X;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= PLAY_X;
        end else begin
            r_state <= w_next;
        end
    end

    // Cell registers: cleared on new_game, written once by a legal move.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                r_board[i] <= 2'b00;
            end
        end else if (new_game) begin
            for (int i = 0; i < 9; i++) begin
                r_board[i] <= 2'b00;
            end
        end else if (w_write) begin
            for (int i = 0; i < 9; i++) begin
                if (move_pos == 4'(i + 1)) begin
                    r_board[i] <= w_mark;
                end
            end
        end
    end

    // Move counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= 4'd0;
        end else if (new_game) begin
            r_count <= 4'd0;
        end else if (w_write) begin
            r_count <= r_count + 4'd1;
        end
    end

    // Turn follows the PLAY state and holds its last value through DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_turn <= 1'b0;
        end else if (w_next == PLAY_O) begin
            r_turn <= 1'b1;
        end else if (w_next == PLAY_X) begin
            r_turn <= 1'b0;
        end
    end

    // One-cycle result pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc <= 1'b0;
            r_ill <= 1'b0;
        end else begin
            r_acc <= w_write;
            r_ill <= w_reject;
        end
    end

    assign move_accepted = r_acc;
    assign illegal_move  = r_ill;
    assign turn          = r_turn;
    assign move_count    = r_count;
    assign pos1          = r_board[0];
    assign pos2          = r_board[1];
    assign pos3          = r_board[2];
    assign pos4          = r_board[3];
    assign pos5          = r_board[4];
    assign pos6          = r_board[5];
    assign pos7          = r_board[6];
    assign pos8          = r_board[7];
    assign pos9          = r_board[8];

endmodule

// File: tb/tb_board_writer.sv
// Self-checking bench for board_writer: a behavioural game model feeds
// a scoreboard queue that is compared against the DUT after each edge.
module tb_board_writer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_pos = 4'd0;
    logic       game_over = 1'b0;
    logic       move_ready;
    logic       move_accepted;
    logic       illegal_move;
    logic       turn;
    logic [3:0] move_count;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;

    board_writer dut (
        .clock         (clock),
        .reset         (reset),
        .new_game      (new_game),
        .move_valid    (move_valid),
        .move_pos      (move_pos),
        .game_over     (game_over),
        .move_ready    (move_ready),
        .move_accepted (move_accepted),
        .illegal_move  (illegal_move),
        .turn          (turn),
        .move_count    (move_count),
        .pos1          (pos1),
        .pos2          (pos2),
        .pos3          (pos3),
        .pos4          (pos4),
        .pos5          (pos5),
        .pos6          (pos6),
        .pos7          (pos7),
        .pos8          (pos8),
        .pos9          (pos9)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        acc;
        logic        ill;
        logic [3:0]  cnt;
        logic        trn;
        logic        rdy;
        logic [17:0] brd;
    } exp_t;

    exp_t q[$];

    int n_total = 0;
    int n_bad   = 0;

    logic [1:0] m_board [9];
    int         m_state;
    int         m_count;
    logic       m_turn;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t observe();
        exp_t o;
        o.acc = move_accepted;
        o.ill = illegal_move;
        o.cnt = move_count;
        o.trn = turn;
        o.rdy = move_ready;
        o.brd = {pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
        return o;
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] b;
        for (int i = 0; i < 9; i++) begin
            b[17 - 2*i -: 2] = m_board[i];
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_board[i] = 2'b00;
        m_state = 0;
        m_count = 0;
        m_turn  = 1'b0;
    endtask

    // Advance the model by one edge and return the expected outputs.
    task automatic model_step(input logic v, input logic [3:0] p,
                              input logic go, input logic ng,
                              output exp_t e);
        int k;
        e = '0;
        k = int'(p) - 1;
        if (ng) begin
            model_reset();
        end else if (m_state != 2) begin
            if (go) begin
                m_state = 2;
            end else if (v) begin
                if (k >= 0 && k <= 8 && m_board[k] == 2'b00) begin
                    m_board[k] = (m_state == 1) ? 2'b10 : 2'b01;
                    m_count++;
                    e.acc = 1'b1;
                    if (m_count == 9) m_state = 2;
                    else m_state = (m_state == 0) ? 1 : 0;
                end else begin
                    e.ill = 1'b1;
                end
            end
        end
        if (m_state != 2) m_turn = (m_state == 1);
        e.cnt = 4'(m_count);
        e.trn = m_turn;
        e.rdy = (m_state != 2);
        e.brd = model_board();
    endtask

    task automatic compare_front();
        exp_t e;
        exp_t o;
        if (q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        o = observe();
        check("accepted", 32'(o.acc), 32'(e.acc));
        check("illegal",  32'(o.ill), 32'(e.ill));
        check("count",    32'(o.cnt), 32'(e.cnt));
        check("turn",     32'(o.trn), 32'(e.trn));
        check("ready",    32'(o.rdy), 32'(e.rdy));
        check("board",    32'(o.brd), 32'(e.brd));
    endtask

    task automatic cycle(input logic v, input logic [3:0] p,
                         input logic go, input logic ng);
        exp_t e;
        move_valid = v;
        move_pos   = p;
        game_over  = go;
        new_game   = ng;
        model_step(v, p, go, ng, e);
        q.push_back(e);
        @(posedge clock);
        #1;
        move_valid = 1'b0;
        new_game   = 1'b0;
        game_over  = 1'b0;
        compare_front();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_board"}, 32'({pos1, pos2, pos3, pos4, pos5,
                                     pos6, pos7, pos8, pos9}), 32'd0);
        check({tag, "_count"}, 32'(move_count), 32'd0);
        check({tag, "_turn"},  32'(turn), 32'd0);
        check({tag, "_ready"}, 32'(move_ready), 32'd1);
        check({tag, "_acc"},   32'(move_accepted), 32'd0);
        check({tag, "_ill"},   32'(illegal_move), 32'd0);
    endtask

    initial begin
        int n_x;
        int n_o;
        logic [1:0] cells [9];
        model_reset();
        #12;
        check_reset_vals("rst");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Two moves back to back.
        cycle(1, 4'd5, 0, 0);
        cycle(1, 4'd1, 0, 0);
        check("pos5_x", 32'(pos5), 32'd1);
        check("pos1_o", 32'(pos1), 32'd2);
        check("two_cnt", 32'(move_count), 32'd2);
        check("two_turn", 32'(turn), 32'd0);

        // Occupied and out-of-range cells are rejected.
        cycle(0, 4'd0, 0, 1);
        cycle(1, 4'd3, 0, 0);
        cycle(1, 4'd3, 0, 0);
        check("occ_ill", 32'(illegal_move), 32'd1);
        cycle(1, 4'd0, 0, 0);
        check("zero_ill", 32'(illegal_move), 32'd1);
        cycle(1, 4'd12, 0, 0);
        check("twelve_ill", 32'(illegal_move), 32'd1);
        check("pos3_hold", 32'(pos3), 32'd1);
        check("ill_turn", 32'(turn), 32'd1);
        check("ill_cnt", 32'(move_count), 32'd1);
        cycle(0, 4'd0, 0, 0);
        check("ill_drop", 32'(illegal_move), 32'd0);

        // Full board.
        cycle(0, 4'd0, 0, 1);
        for (int i = 1; i <= 9; i++) cycle(1, 4'(i), 0, 0);
        check("full_cnt", 32'(move_count), 32'd9);
        check("full_rdy", 32'(move_ready), 32'd0);
        cells = '{pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
        n_x = 0;
        n_o = 0;
        for (int i = 0; i < 9; i++) begin
            if (cells[i] == 2'b01) n_x++;
            if (cells[i] == 2'b10) n_o++;
        end
        check("full_x", 32'(n_x), 32'd5);
        check("full_o", 32'(n_o), 32'd4);
        cycle(1, 4'd5, 0, 0);
        check("done_noacc", 32'(move_accepted), 32'd0);
        check("done_noill", 32'(illegal_move), 32'd0);

        // new_game from DONE.
        cycle(0, 4'd0, 0, 1);
        check_reset_vals("ng");

        // game_over beats a coincident legal move.
        cycle(1, 4'd1, 0, 0);
        cycle(1, 4'd2, 0, 0);
        cycle(1, 4'd3, 0, 0);
        cycle(1, 4'd4, 1, 0);
        check("go_cnt", 32'(move_count), 32'd3);
        check("go_acc", 32'(move_accepted), 32'd0);
        check("go_rdy", 32'(move_ready), 32'd0);
        check("go_pos4", 32'(pos4), 32'd0);
        cycle(0, 4'd0, 1, 0);
        cycle(1, 4'd4, 0, 0);

        // new_game beats a move in PLAY_O.
        cycle(0, 4'd0, 0, 1);
        cycle(1, 4'd7, 0, 0);
        cycle(1, 4'd8, 0, 1);
        check_reset_vals("ngmove");

        // Asynchronous reset with four cells written and a move pending.
        cycle(1, 4'd1, 0, 0);
        cycle(1, 4'd2, 0, 0);
        cycle(1, 4'd3, 0, 0);
        cycle(1, 4'd4, 0, 0);
        check("pre_rst_cnt", 32'(move_count), 32'd4);
        move_valid = 1'b1;
        move_pos   = 4'd7;
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("arst");
        model_reset();
        @(posedge clock);
        #1;
        check("arst_pos7", 32'(pos7), 32'd0);
        move_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        cycle(1, 4'd9, 0, 0);
        check("post_rst_x", 32'(pos9), 32'd1);

        // Random play with occasional game_over and new_game.
        for (int i = 0; i < 150; i++) begin
            cycle(($urandom % 4) != 0, 4'($urandom_range(0, 11)),
                  ($urandom % 16) == 0, ($urandom % 20) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/board_writer.md
# board_writer

Sequential board-state writer for the tic-tac-toe game. It accepts one move per handshake from the player-input or computer-move logic and checks each move against the current board. Legal moves are written into the nine 2-bit position registers, and the turn alternates between players. The pos1..pos9 outputs drive the full-board and win detectors, and their results return as game_over.

## Interface
Parameters:
- none; the board is fixed at nine cells, and the cell encoding is fixed: 2'b00 empty, 2'b01 player X, 2'b10 player O, 2'b11 never written.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- new_game  input  1  synchronous clear to the start-of-game state; honoured in any state.
- move_valid  input  1  the requester presents a move this cycle.
- move_pos  input  4  target cell, 1..9; values 0 and 10..15 are illegal.
- game_over  input  1  from the win and full-board detectors; ends play.
- move_ready  output  1  high in PLAY_X and PLAY_O; a move is taken only when move_valid & move_ready.
- move_accepted  output  1  one-cycle pulse; the move was written.
- illegal_move  output  1  one-cycle pulse; the move was rejected and the board is unchanged.
- turn  output  1  0 = X to move, 1 = O to move.
- move_count  output  4  number of cells written this game, 0..9.
- pos1..pos9  output  2 each  registered cell contents.

## Operation
- States: PLAY_X, PLAY_O, DONE. Reset and new_game both enter PLAY_X.
- Priority each cycle, highest first:
  - new_game
  - game_over
  - move handshake
- new_game: all pos registers go to 00; move_count, turn, illegal_move and move_accepted go to 0; state goes to PLAY_X. A coincident move is dropped and no pulse is produced.
- game_over high in PLAY_X or PLAY_O: go to DONE. A coincident move is dropped and no pulse is produced.
- Handshake in PLAY_X or PLAY_O (move_valid & move_ready):
  - Legal means move_pos is in 1..9 and the addressed cell is 00.
  - Legal move: write 01 (PLAY_X) or 10 (PLAY_O) to the cell, pulse move_accepted, increment move_count, flip to the other PLAY state.
  - If the increment takes move_count to 9, go to DONE instead of the other PLAY state.
  - Illegal move: pulse illegal_move. The board, count and state do not change, and the same player moves again.
- DONE:
  - move_ready is 0 and move_valid is ignored; neither pulse fires.
  - The board holds until new_game.
  - game_over has no further effect.
- turn = 1 exactly when the state is PLAY_O. In DONE, turn holds the value of the last PLAY state.
- A cell is written at most once per game, so no pos output ever shows 11.

## Timing
- Reset values:
  - pos1..pos9 = 00
  - move_count = 0, turn = 0
  - move_accepted = 0, illegal_move = 0
  - move_ready = 1 (PLAY_X)
- Reset takes effect asynchronously. If it arrives mid-move, the move is discarded and outputs are at their reset values before the next edge.
- Latency is one cycle: a handshake at edge N updates pos, move_count, turn and the pulses in the cycle after N. The pulses drop after one cycle unless a new handshake occurs.
- move_ready is decoded from state only and does not depend on move_valid combinationally.
- Back-to-back moves on consecutive cycles are supported, with alternating players.
- game_over is sampled registered: a detector result produced from the updated board ends play at the next edge. A move presented in that same cycle loses to game_over.

## Test plan
- Reset, then move_pos=5 at cycle 1 and move_pos=1 at cycle 2 → pos5=01, pos1=10, move_count=2, turn=0, two move_accepted pulses.
- X at 3, then O at 3 → illegal_move pulses once, pos3 stays 01, turn stays 1, move_count=1. Repeat with move_pos=0 and move_pos=12 → illegal_move each time, no state change.
- Nine legal alternating moves → DONE after the 9th: move_count=9, move_ready=0, five cells = 01, four cells = 10. A further move_valid produces no pulse.
- game_over asserted together with a legal move after 3 moves → DONE, move dropped, move_count=3, no move_accepted.
- In DONE, assert new_game → next cycle all pos = 00, move_count=0, turn=0, move_ready=1. Also assert new_game simultaneously with a move in PLAY_O → board cleared, no pulse.
- Assert reset asynchronously between edges with 4 cells written → outputs at reset values immediately. The first move after deassertion is written as 01.
